// File: rtl/pc_branch_unit.sv
// Program counter / branch-resolution stage: picks the next PC (increment, relative branch, hold)
// and detects the halt idiom. Optional macro BRANCH_STATS_EN adds a saturating taken-branch counter.
module pc_branch_unit #(
    parameter int Psize = 6
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             stall,
    input  logic [1:0]       br_ctrl,
    input  logic             flag,
    input  logic [Psize-1:0] offset,
    output logic [Psize-1:0] pc,
    output logic             pc_valid,
    output logic             take_branch,
    output logic             halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      br_count
`endif
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_t;

    state_t           state_q;
    logic [Psize-1:0] pc_q, pc_d;
    logic             pc_valid_q, halted_q;
    logic             br_cond;
    logic             halt_d;

    // br_ctrl==00 must not look at flag, so an X flag cannot leak into pc.
    always_comb begin
        br_cond = 1'b0;
        case (br_ctrl)
            2'b01:   br_cond = flag;
            2'b10:   br_cond = ~flag;
            2'b11:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign take_branch = br_cond && (state_q == S_RUN) && !stall;
    assign halt_d      = take_branch && (offset == '0);
    // Same-width add gives the modulo-2**Psize wrap with the offset sign-extended for free.
    assign pc_d        = take_branch ? pc_q + offset : pc_q + {{(Psize-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_INIT;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (!stall) begin
                        state_q    <= S_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (halt_d) begin
                            state_q    <= S_HALT;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                S_HALT: begin
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q    <= S_INIT;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign halted   = halted_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] br_count_q;

    // take_branch already excludes stall and non-RUN states, so the halting branch counts too.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            br_count_q <= '0;
        end else if (take_branch && (br_count_q != 16'hFFFF)) begin
            br_count_q <= br_count_q + 16'd1;
        end
    end

    assign br_count = br_count_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboarded random + directed bench for pc_branch_unit against a behavioural PC model.
module tb_pc_branch_unit;

    localparam int P   = 6;
    localparam int MOD = 1 << P;

    logic         clk = 1'b0;
    logic         nReset = 1'b0;
    logic         stall = 1'b0;
    logic [1:0]   br_ctrl = 2'b00;
    logic         flag = 1'b0;
    logic [P-1:0] offset = '0;
    logic [P-1:0] pc;
    logic         pc_valid, take_branch, halted;
`ifdef BRANCH_STATS_EN
    logic [15:0]  br_count;
`endif

    pc_branch_unit #(.Psize(P)) dut (
        .clk(clk), .nReset(nReset), .stall(stall), .br_ctrl(br_ctrl), .flag(flag),
        .offset(offset), .pc(pc), .pc_valid(pc_valid), .take_branch(take_branch),
        .halted(halted)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit valid;
        bit halt;
        int cnt;
    } exp_t;

    exp_t q_st[$];
    bit   q_tb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: mode 0 = waiting for first edge, 1 = running, 2 = halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    function automatic int sext(input int o);
        return (o >= MOD / 2) ? o - MOD : o;
    endfunction

    task automatic cyc(input bit rst_n, input bit [1:0] br, input bit fl, input int off, input bit st);
        bit t;
        exp_t e;
        @(negedge clk);
        nReset  = rst_n;
        br_ctrl = br;
        flag    = fl;
        offset  = P'(off);
        stall   = st;
        t = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else begin
            if (m_mode == 1 && !st)
                t = (br == 2'b11) || (br == 2'b01 && fl) || (br == 2'b10 && !fl);
            if (t && m_cnt < 65535) m_cnt++;
            if (m_mode == 0) begin
                if (!st) m_mode = 1;
            end else if (m_mode == 1 && !st) begin
                if (t && (off % MOD) == 0) m_mode = 2;
                else if (t) m_pc = (((m_pc + sext(off % MOD)) % MOD) + MOD) % MOD;
                else m_pc = (m_pc + 1) % MOD;
            end
        end
        e.pc = m_pc; e.valid = (m_mode == 1); e.halt = (m_mode == 2); e.cnt = m_cnt;
        #2;
        q_tb.push_back(t);
        q_st.push_back(e);
    endtask

    // Jump to a target PC with an unconditional branch (model-tracked).
    task automatic goto_pc(input int target);
        int d;
        d = ((target - m_pc) % MOD + MOD) % MOD;
        if (d != 0) cyc(1, 2'b11, 0, d, 0);
    endtask

    // Monitor: combinational decision, sampled mid low phase.
    initial forever begin
        @(negedge clk);
        #3;
        if (q_tb.size() > 0) begin
            bit e;
            e = q_tb.pop_front();
            n_cmp++;
            if (take_branch !== e) begin
                n_bad++;
                $display("FAIL take_branch: got %0b want %0b at %0t", take_branch, e, $time);
            end
        end
    end

    // Monitor: registered outputs, sampled just after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (q_st.size() > 0) begin
            exp_t e;
            e = q_st.pop_front();
            n_cmp++;
            if (pc !== P'(e.pc) || pc_valid !== e.valid || halted !== e.halt) begin
                n_bad++;
                $display("FAIL state: got pc=%0d v=%0b h=%0b want pc=%0d v=%0b h=%0b at %0t",
                         pc, pc_valid, halted, e.pc, e.valid, e.halt, $time);
            end
`ifdef BRANCH_STATS_EN
            n_cmp++;
            if (br_count !== 16'(e.cnt)) begin
                n_bad++;
                $display("FAIL br_count: got %0d want %0d at %0t", br_count, e.cnt, $time);
            end
`endif
        end
    end

    // Monitor: asynchronous reset must clear registered outputs without waiting for a clock.
    initial forever begin
        @(negedge nReset);
        #1;
        n_cmp++;
        if (pc !== '0 || pc_valid !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got pc=%0d v=%0b h=%0b want pc=0 v=0 h=0", pc, pc_valid, halted);
        end
    end

    initial begin
        int w;
        // T1: reset, run to pc=17, then async reset mid-cycle.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (17) cyc(1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        nReset = 1'b0;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);              // stall in INIT stays in INIT
        cyc(1, 0, 0, 0, 0);
        // T2: sequential wrap over 70 cycles, flag/offset noise ignored.
        for (int i = 0; i < 70; i++) cyc(1, 2'b00, $urandom_range(0, 1), $urandom_range(0, MOD - 1), 0);
        // T3: BEQ/BNE at pc=10 with +4 / -4.
        goto_pc(10); cyc(1, 2'b01, 1, 4, 0);
        goto_pc(10); cyc(1, 2'b01, 0, 4, 0);
        goto_pc(10); cyc(1, 2'b10, 0, MOD - 4, 0);
        goto_pc(10); cyc(1, 2'b10, 1, MOD - 4, 0);
        goto_pc(2);  cyc(1, 2'b11, 0, MOD - 3, 0);   // wraps to 63
        cyc(1, 2'b00, 0, 0, 0);                      // 63 -> 0
        // T4: stalled branch held for 3 cycles, then taken.
        goto_pc(20);
        repeat (3) cyc(1, 2'b01, 1, 5, 1);
        cyc(1, 2'b01, 1, 5, 0);
        // T5: halt idiom, hold 10 cycles, reset exits.
        goto_pc(30);
        cyc(1, 2'b11, 0, 0, 0);
        repeat (10) cyc(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, MOD - 1), $urandom_range(0, 1));
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // T6-style counting: 5 taken, 3 untaken, 1 stalled.
        repeat (5) cyc(1, 2'b11, 0, 1, 0);
        cyc(1, 2'b01, 0, 3, 0); cyc(1, 2'b10, 1, 3, 0); cyc(1, 2'b00, 1, 3, 0);
        cyc(1, 2'b11, 0, 2, 1);
        // Random soak; reset whenever the model reaches HALT for a while.
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 0);
            else cyc(1, $urandom_range(0, 3), $urandom_range(0, 1),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MOD - 1),
                     $urandom_range(0, 4) == 0);
        end
        w = 0;
        while ((q_st.size() > 0 || q_tb.size() > 0) && w < 20) begin
            @(posedge clk);
            w++;
        end
        if (q_st.size() > 0 || q_tb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d entries left, want 0", q_st.size(), q_tb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
